// File: rtl/semaforo_pkg.sv
// Shared types and lamp encodings for the traffic-light safety monitor.
package semaforo_pkg;

    typedef enum logic [2:0] {
        PH_DARK,
        PH_CAR_GO,
        PH_CAR_WARN,
        PH_PED_GO,
        PH_PED_STOP,
        PH_PED_BLANK,
        PH_BLINK,
        PH_ILLEGAL
    } phase_t;

    typedef enum logic [2:0] {
        FLT_NONE,
        FLT_ILLEGAL,
        FLT_BAD_SEQ,
        FLT_SHORT_GREEN,
        FLT_BAD_WARN,
        FLT_BAD_PED,
        FLT_BAD_FLASH,
        FLT_STUCK
    } fault_t;

    // Lamp vectors ordered {gc, yc, rc, gp, rp}
    localparam logic [4:0] LAMP_DARK      = 5'b00000;
    localparam logic [4:0] LAMP_CAR_GO    = 5'b10001;
    localparam logic [4:0] LAMP_CAR_WARN  = 5'b01001;
    localparam logic [4:0] LAMP_PED_GO    = 5'b00110;
    localparam logic [4:0] LAMP_PED_STOP  = 5'b00101;
    localparam logic [4:0] LAMP_PED_BLANK = 5'b00100;
    localparam logic [4:0] LAMP_BLINK     = 5'b01000;

    function automatic logic seq_legal(input phase_t from_ph, input phase_t to_ph);
        case (from_ph)
            PH_DARK:      return (to_ph == PH_CAR_GO)   || (to_ph == PH_BLINK);
            PH_BLINK:     return (to_ph == PH_DARK)     || (to_ph == PH_CAR_GO);
            PH_CAR_GO:    return (to_ph == PH_CAR_WARN) || (to_ph == PH_BLINK);
            PH_CAR_WARN:  return (to_ph == PH_PED_GO)   || (to_ph == PH_BLINK);
            PH_PED_GO:    return (to_ph == PH_PED_STOP) || (to_ph == PH_BLINK);
            PH_PED_STOP:  return (to_ph == PH_PED_BLANK) || (to_ph == PH_CAR_GO) ||
                                 (to_ph == PH_BLINK);
            PH_PED_BLANK: return (to_ph == PH_PED_STOP) || (to_ph == PH_BLINK);
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_lamp_decode.sv
// Combinational decode of the five lamp drives into a phase.
module semaforo_lamp_decode
    import semaforo_pkg::*;
(
    input  logic [4:0] i_lamps,
    output phase_t     o_phase
);

    always_comb begin
        o_phase = PH_ILLEGAL;
        case (i_lamps)
            LAMP_DARK:      o_phase = PH_DARK;
            LAMP_CAR_GO:    o_phase = PH_CAR_GO;
            LAMP_CAR_WARN:  o_phase = PH_CAR_WARN;
            LAMP_PED_GO:    o_phase = PH_PED_GO;
            LAMP_PED_STOP:  o_phase = PH_PED_STOP;
            LAMP_PED_BLANK: o_phase = PH_PED_BLANK;
            LAMP_BLINK:     o_phase = PH_BLINK;
            default:        o_phase = PH_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Safety checker beside the traffic-light controller: tracks phase order and
// durations, latches the first violation, and counts clean cycles.
//   phase        | meaning
//   DARK         | all lamps off
//   CAR_GO       | car green, ped red
//   CAR_WARN     | car yellow, ped red
//   PED_GO       | car red, ped green
//   PED_STOP     | car red, ped red (flash on)
//   PED_BLANK    | car red, ped dark (flash off)
//   BLINK        | car yellow only, alarm mode
//   ILLEGAL      | any other lamp pattern
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int CAR_MIN   = 6,
    parameter int WARN_LEN  = 1,
    parameter int PED_LEN   = 4,
    parameter int FLASH_LEN = 5,
    parameter int MAX_HOLD  = 64,
    parameter int CW        = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_gc,
    input  logic          i_yc,
    input  logic          i_rc,
    input  logic          i_gp,
    input  logic          i_rp,
    input  logic          i_clr_fault,
    output phase_t        o_phase,
    output logic [CW-1:0] o_run_len,
    output logic          o_fault,
    output fault_t        o_fault_code,
    output logic          o_cycle_done,
    output logic [15:0]   o_cycle_cnt
);

    phase_t        r_phase;
    logic [CW-1:0] r_run_len;
    logic          r_fault;
    fault_t        r_fault_code;
    logic          r_cycle_done;
    logic [15:0]   r_cycle_cnt;
    logic          r_armed;
    logic [CW-1:0] r_flash_cnt;

    phase_t        w_new;
    logic          w_changed;
    logic          w_chk;
    logic          w_dur;
    logic [7:0]    w_flt;
    fault_t        w_det;
    logic [CW-1:0] w_run_nx;
    logic          w_fault_nx;
    fault_t        w_code_nx;
    logic          w_done_nx;
    logic [15:0]   w_cnt_nx;
    logic          w_armed_nx;
    logic [CW-1:0] w_flash_nx;

    semaforo_lamp_decode u_decode (
        .i_lamps ({i_gc, i_yc, i_rc, i_gp, i_rp}),
        .o_phase (w_new)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase      <= PH_DARK;
            r_run_len    <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
            r_cycle_done <= 1'b0;
            r_cycle_cnt  <= '0;
            r_armed      <= 1'b0;
            r_flash_cnt  <= '0;
        end else begin
            r_phase      <= w_new;
            r_run_len    <= w_run_nx;
            r_fault      <= w_fault_nx;
            r_fault_code <= w_code_nx;
            r_cycle_done <= w_done_nx;
            r_cycle_cnt  <= w_cnt_nx;
            r_armed      <= w_armed_nx;
            r_flash_cnt  <= w_flash_nx;
        end
    end

    always_comb begin
        w_changed = (w_new != r_phase);
        w_chk     = r_armed && w_changed;
        // A jump into BLINK is an alarm preemption, so durations are not judged
        w_dur     = w_chk && (w_new != PH_BLINK);

        if (w_changed)
            w_run_nx = CW'(1);
        else if (r_run_len == {CW{1'b1}})
            w_run_nx = r_run_len;
        else
            w_run_nx = r_run_len + CW'(1);

        w_flt = '0;
        w_flt[FLT_ILLEGAL] = (w_new == PH_ILLEGAL);
        w_flt[FLT_BAD_SEQ] = w_chk && (r_phase != PH_ILLEGAL) && (w_new != PH_ILLEGAL) &&
                             !seq_legal(r_phase, w_new);
        w_flt[FLT_SHORT_GREEN] = w_dur && (r_phase == PH_CAR_GO) && (w_new == PH_CAR_WARN) &&
                                 (r_run_len < CW'(CAR_MIN));
        w_flt[FLT_BAD_WARN] = w_dur && (r_phase == PH_CAR_WARN) && (r_run_len != CW'(WARN_LEN));
        w_flt[FLT_BAD_PED]  = w_dur && (r_phase == PH_PED_GO) && (r_run_len != CW'(PED_LEN));
        w_flt[FLT_BAD_FLASH] = w_dur &&
            ((((r_phase == PH_PED_STOP) || (r_phase == PH_PED_BLANK)) && (r_run_len != CW'(1))) ||
             ((r_phase == PH_PED_STOP) && (w_new == PH_CAR_GO) &&
              (r_flash_cnt != CW'(FLASH_LEN))));
        w_flt[FLT_STUCK] = !w_changed && (r_phase != PH_DARK) &&
                           (r_run_len == CW'(MAX_HOLD - 1));

        w_det = FLT_NONE;
        if      (w_flt[FLT_ILLEGAL])     w_det = FLT_ILLEGAL;
        else if (w_flt[FLT_BAD_SEQ])     w_det = FLT_BAD_SEQ;
        else if (w_flt[FLT_SHORT_GREEN]) w_det = FLT_SHORT_GREEN;
        else if (w_flt[FLT_BAD_WARN])    w_det = FLT_BAD_WARN;
        else if (w_flt[FLT_BAD_PED])     w_det = FLT_BAD_PED;
        else if (w_flt[FLT_BAD_FLASH])   w_det = FLT_BAD_FLASH;
        else if (w_flt[FLT_STUCK])       w_det = FLT_STUCK;

        w_fault_nx = r_fault;
        w_code_nx  = r_fault_code;
        if (w_det != FLT_NONE) begin
            w_fault_nx = 1'b1;
            if (!r_fault)
                w_code_nx = w_det;
        end else if (i_clr_fault) begin
            w_fault_nx = 1'b0;
            w_code_nx  = FLT_NONE;
        end

        w_done_nx = r_armed && (r_phase == PH_PED_STOP) && (w_new == PH_CAR_GO) &&
                    (w_det == FLT_NONE);
        w_cnt_nx  = w_done_nx ? r_cycle_cnt + 16'd1 : r_cycle_cnt;

        w_armed_nx = r_armed || (w_changed && (w_new == PH_CAR_GO));

        w_flash_nx = r_flash_cnt;
        if ((r_phase == PH_PED_GO) && (w_new == PH_PED_STOP))
            w_flash_nx = CW'(1);
        else if (((r_phase == PH_PED_STOP) && (w_new == PH_PED_BLANK)) ||
                 ((r_phase == PH_PED_BLANK) && (w_new == PH_PED_STOP))) begin
            if (r_flash_cnt != {CW{1'b1}})
                w_flash_nx = r_flash_cnt + CW'(1);
        end
    end

    always_comb begin
        o_phase      = r_phase;
        o_run_len    = r_run_len;
        o_fault      = r_fault;
        o_fault_code = r_fault_code;
        o_cycle_done = r_cycle_done;
        o_cycle_cnt  = r_cycle_cnt;
    end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: per-segment vector table plus hand sequences.
module tb_semaforo_monitor;
    import semaforo_pkg::*;

    localparam logic [4:0] L_ILL = 5'b10010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  lamps = 5'b00000;
    logic        clr = 1'b0;
    phase_t      phase;
    logic [7:0]  run_len;
    logic        fault;
    fault_t      fault_code;
    logic        cycle_done;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    semaforo_monitor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_gc         (lamps[4]),
        .i_yc         (lamps[3]),
        .i_rc         (lamps[2]),
        .i_gp         (lamps[1]),
        .i_rp         (lamps[0]),
        .i_clr_fault  (clr),
        .o_phase      (phase),
        .o_run_len    (run_len),
        .o_fault      (fault),
        .o_fault_code (fault_code),
        .o_cycle_done (cycle_done),
        .o_cycle_cnt  (cycle_cnt)
    );

    typedef struct {
        bit         rst_first;
        logic [4:0] lamps;
        int         n;
        bit         clr;
        phase_t     exp_phase;
        int         exp_run;
        bit         exp_fault;
        fault_t     exp_code;
        bit         exp_done;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [4:0] l, int n, bit c, phase_t p, int run,
                                bit f, fault_t fc, bit d, int cnt);
        vec_t v;
        v.rst_first = r; v.lamps = l; v.n = n; v.clr = c;
        v.exp_phase = p; v.exp_run = run; v.exp_fault = f; v.exp_code = fc;
        v.exp_done = d; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        lamps = LAMP_DARK;
        clr   = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
    endtask

    task automatic chk_all(input string tag, input phase_t p, input int run, input bit f,
                           input fault_t fc, input bit d, input int cnt);
        chk({tag, " phase"},      int'(phase),      int'(p));
        chk({tag, " run_len"},    int'(run_len),    run);
        chk({tag, " fault"},      int'(fault),      int'(f));
        chk({tag, " fault_code"}, int'(fault_code), int'(fc));
        chk({tag, " cycle_done"}, int'(cycle_done), int'(d));
        chk({tag, " cycle_cnt"},  int'(cycle_cnt),  cnt);
    endtask

    initial begin
        // Nominal cycles: three clean PED_STOP->CAR_GO transitions
        vecs.push_back(mk(1, LAMP_DARK,   1, 0, PH_DARK,   1, 0, FLT_NONE, 0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO, 6, 0, PH_CAR_GO, 6, 0, FLT_NONE, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            vecs.push_back(mk(0, LAMP_CAR_WARN,  1, 0, PH_CAR_WARN,  1, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_PED_GO,    4, 0, PH_PED_GO,    4, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_PED_STOP,  1, 0, PH_PED_STOP,  1, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_PED_BLANK, 1, 0, PH_PED_BLANK, 1, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_PED_STOP,  1, 0, PH_PED_STOP,  1, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_PED_BLANK, 1, 0, PH_PED_BLANK, 1, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_PED_STOP,  1, 0, PH_PED_STOP,  1, 0, FLT_NONE, 0, k-1));
            vecs.push_back(mk(0, LAMP_CAR_GO,    1, 0, PH_CAR_GO,    1, 0, FLT_NONE, 1, k));
            vecs.push_back(mk(0, LAMP_CAR_GO,    5, 0, PH_CAR_GO,    6, 0, FLT_NONE, 0, k));
        end
        // Illegal lamp pattern, sticky after lamps recover
        vecs.push_back(mk(1, LAMP_DARK, 1, 0, PH_DARK,    1, 0, FLT_NONE,    0, 0));
        vecs.push_back(mk(0, L_ILL,     1, 0, PH_ILLEGAL, 1, 1, FLT_ILLEGAL, 0, 0));
        vecs.push_back(mk(0, LAMP_DARK, 3, 0, PH_DARK,    3, 1, FLT_ILLEGAL, 0, 0));
        // Short green, then clear
        vecs.push_back(mk(1, LAMP_DARK,     1, 0, PH_DARK,     1, 0, FLT_NONE,        0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   4, 0, PH_CAR_GO,   4, 0, FLT_NONE,        0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 1, 0, PH_CAR_WARN, 1, 1, FLT_SHORT_GREEN, 0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 1, 1, PH_CAR_WARN, 2, 0, FLT_NONE,        0, 0));
        // Bad sequence, clear, then faults colliding with clear
        vecs.push_back(mk(1, LAMP_DARK,     1, 0, PH_DARK,     1, 0, FLT_NONE,        0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   6, 0, PH_CAR_GO,   6, 0, FLT_NONE,        0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 1, 0, PH_CAR_WARN, 1, 0, FLT_NONE,        0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   1, 0, PH_CAR_GO,   1, 1, FLT_BAD_SEQ,     0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   1, 1, PH_CAR_GO,   2, 0, FLT_NONE,        0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 1, 1, PH_CAR_WARN, 1, 1, FLT_SHORT_GREEN, 0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   1, 1, PH_CAR_GO,   1, 1, FLT_SHORT_GREEN, 0, 0));
        // BLINK preemption, then a short flash
        vecs.push_back(mk(1, LAMP_DARK,      1, 0, PH_DARK,      1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,    6, 0, PH_CAR_GO,    6, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN,  1, 0, PH_CAR_WARN,  1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_PED_GO,    2, 0, PH_PED_GO,    2, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_BLINK,     1, 0, PH_BLINK,     1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_DARK,      1, 0, PH_DARK,      1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_BLINK,     1, 0, PH_BLINK,     1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_DARK,      1, 0, PH_DARK,      1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,    1, 0, PH_CAR_GO,    1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,    5, 0, PH_CAR_GO,    6, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN,  1, 0, PH_CAR_WARN,  1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_PED_GO,    4, 0, PH_PED_GO,    4, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_PED_STOP,  1, 0, PH_PED_STOP,  1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_PED_BLANK, 1, 0, PH_PED_BLANK, 1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_PED_STOP,  1, 0, PH_PED_STOP,  1, 0, FLT_NONE,      0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,    1, 0, PH_CAR_GO,    1, 1, FLT_BAD_FLASH, 0, 0));
        // Unarmed: out-of-order phase tolerated
        vecs.push_back(mk(1, LAMP_DARK,     1, 0, PH_DARK,     1, 0, FLT_NONE, 0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 1, 0, PH_CAR_WARN, 1, 0, FLT_NONE, 0, 0));
        // Warn too long
        vecs.push_back(mk(1, LAMP_DARK,     1, 0, PH_DARK,     1, 0, FLT_NONE,     0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   6, 0, PH_CAR_GO,   6, 0, FLT_NONE,     0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 2, 0, PH_CAR_WARN, 2, 0, FLT_NONE,     0, 0));
        vecs.push_back(mk(0, LAMP_PED_GO,   1, 0, PH_PED_GO,   1, 1, FLT_BAD_WARN, 0, 0));
        // Pedestrian green too short
        vecs.push_back(mk(1, LAMP_DARK,     1, 0, PH_DARK,     1, 0, FLT_NONE,    0, 0));
        vecs.push_back(mk(0, LAMP_CAR_GO,   6, 0, PH_CAR_GO,   6, 0, FLT_NONE,    0, 0));
        vecs.push_back(mk(0, LAMP_CAR_WARN, 1, 0, PH_CAR_WARN, 1, 0, FLT_NONE,    0, 0));
        vecs.push_back(mk(0, LAMP_PED_GO,   3, 0, PH_PED_GO,   3, 0, FLT_NONE,    0, 0));
        vecs.push_back(mk(0, LAMP_PED_STOP, 1, 0, PH_PED_STOP, 1, 1, FLT_BAD_PED, 0, 0));

        // Reset values before the first edge
        do_reset();
        chk_all("reset", PH_DARK, 0, 0, FLT_NONE, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset();
            lamps = vecs[i].lamps;
            clr   = vecs[i].clr;
            repeat (vecs[i].n) tick();
            clr = 1'b0;
            chk_all($sformatf("row%0d", i), vecs[i].exp_phase, vecs[i].exp_run,
                    vecs[i].exp_fault, vecs[i].exp_code, vecs[i].exp_done, vecs[i].exp_cnt);
        end

        // Long DARK is never stuck; long CAR_GO is stuck at 64 and run_len saturates
        do_reset();
        lamps = LAMP_DARK;
        repeat (70) tick();
        chk("dark_hold run_len", int'(run_len), 70);
        chk("dark_hold fault", int'(fault), 0);
        lamps = LAMP_CAR_GO;
        repeat (63) tick();
        chk("stuck63 run_len", int'(run_len), 63);
        chk("stuck63 fault", int'(fault), 0);
        tick();
        chk("stuck64 run_len", int'(run_len), 64);
        chk("stuck64 fault", int'(fault), 1);
        chk("stuck64 code", int'(fault_code), int'(FLT_STUCK));
        repeat (191) tick();
        chk("sat255 run_len", int'(run_len), 255);
        tick();
        chk("sat256 run_len", int'(run_len), 255);
        chk("sat256 code", int'(fault_code), int'(FLT_STUCK));

        // Asynchronous reset mid-run, checked before the next clock edge
        rst = 1'b1;
        #2;
        chk_all("async_rst", PH_DARK, 0, 0, FLT_NONE, 0, 0);
        #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
